// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - Default reset PC and the NOP encoding injected on flush/reset.
//   - Phase encoding of the two-phase memory-sharing strobe.
//   - Word-alignment helper for redirect targets.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] PC_STEP       = 32'd4;

  // FETCH_PHASE: memory serves instruction fetch. DATA_PHASE: memory serves load/store.
  typedef enum logic {
    FETCH_PHASE = 1'b0,
    DATA_PHASE  = 1'b1
  } phase_e;

  // Redirect targets are forced onto a word boundary; misalignment is flagged separately.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program-counter register: 32-bit, asynchronous active-high reset, load enable.
// Ports:
//   clk     in   clock
//   rst     in   async active-high reset, loads RESET_VAL
//   load_i  in   when 1, q_o takes d_i on the rising edge
//   d_i     in   next PC value
//   q_o     out  current PC
module fetch_stage_pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else if (load_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, generates the tick_tock phase strobe that time-shares the single-ported
// memory between fetch (tick_tock=0) and data access (tick_tock=1), and presents
// IR/PC to decode. One instruction is captured every two clocks, on the edge that
// ends the FETCH phase.
// Ports:
//   clk          in   core clock
//   rst          in   async active-high reset
//   stall        in   hold PC and IF/ID on the capture edge
//   redirect     in   taken branch/jump: load redirect_pc, squash fetched instr
//   redirect_pc  in   redirect target
//   mem_rdata    in   instruction word read combinationally at mem_addr
//   mem_addr     out  fetch address (= pc)
//   fetch_en     out  1 during FETCH phase
//   tick_tock    out  phase strobe, 1 = DATA phase
//   ir           out  IF/ID instruction register
//   ir_pc        out  PC of ir
//   ir_pc4       out  ir_pc + 4 (link value)
//   ir_valid     out  ir holds a real fetched instruction
//   misalign     out  sticky: a misaligned redirect target was applied
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        fetch_en,
  output logic        tick_tock,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_pc4,
  output logic        ir_valid,
  output logic        misalign
);

  phase_e      phase_q, phase_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pc_load;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic [31:0] ir_pc4_q, ir_pc4_d;
  logic        ir_valid_q, ir_valid_d;
  logic        misalign_q, misalign_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;

  logic        capture;
  logic        take_redir;
  logic [31:0] tgt;

  // Phase toggles unconditionally; stall only affects what happens on capture edges.
  assign phase_d = (phase_q == FETCH_PHASE) ? DATA_PHASE : FETCH_PHASE;
  assign capture = (phase_q == FETCH_PHASE);

  // A live redirect on the capture edge beats an older pending one.
  assign tgt        = redirect ? redirect_pc : redir_tgt_q;
  assign take_redir = capture && (redirect || redir_pend_q);

  assign pc_load = capture && (take_redir || !stall);
  assign pc_d    = take_redir ? align_word(tgt) : (pc_q + PC_STEP);

  fetch_stage_pc_reg #(
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst   (rst),
    .load_i(pc_load),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  always_comb begin
    ir_d         = ir_q;
    ir_pc_d      = ir_pc_q;
    ir_pc4_d     = ir_pc4_q;
    ir_valid_d   = ir_valid_q;
    misalign_d   = misalign_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;

    if (capture) begin
      if (take_redir) begin
        // Squash: the word fetched this phase belongs to the wrong path.
        ir_d         = NOP_INSTR;
        ir_valid_d   = 1'b0;
        redir_pend_d = 1'b0;
        misalign_d   = misalign_q | (tgt[1:0] != 2'b00);
      end else if (!stall) begin
        // mem_rdata is only consumed here, so an undriven bus during stall/redirect is harmless.
        ir_d       = mem_rdata;
        ir_pc_d    = pc_q;
        ir_pc4_d   = pc_q + PC_STEP;
        ir_valid_d = 1'b1;
      end
    end else if (redirect) begin
      // Redirect resolved during DATA phase: remember it for the next capture edge.
      redir_pend_d = 1'b1;
      redir_tgt_d  = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q      <= FETCH_PHASE;
      ir_q         <= NOP_INSTR;
      ir_pc_q      <= RESET_PC;
      ir_pc4_q     <= RESET_PC + PC_STEP;
      ir_valid_q   <= 1'b0;
      misalign_q   <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= RESET_PC;
    end else begin
      phase_q      <= phase_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      ir_pc4_q     <= ir_pc4_d;
      ir_valid_q   <= ir_valid_d;
      misalign_q   <= misalign_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

  assign mem_addr  = pc_q;
  assign fetch_en  = (phase_q == FETCH_PHASE);
  assign tick_tock = (phase_q == DATA_PHASE);
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_pc4    = ir_pc4_q;
  assign ir_valid  = ir_valid_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic        fetch_en;
  logic        tick_tock;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [31:0] ir_pc4;
  logic        ir_valid;
  logic        misalign;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .fetch_en   (fetch_en),
    .tick_tock  (tick_tock),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_pc4     (ir_pc4),
    .ir_valid   (ir_valid),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  assign mem_rdata = mem_f(mem_addr);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        v;
    logic        chk_pc;
  } exp_t;

  exp_t sb[$];

  // Reference state
  logic        m_tt;
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic        m_mis;
  logic [31:0] m_ir, m_ir_pc, m_ir_pc4;
  logic        m_v;

  task automatic model_reset();
    m_tt = 1'b0; m_pc = 32'h0; m_pend = 1'b0; m_tgt = 32'h0; m_mis = 1'b0;
    m_ir = NOP; m_ir_pc = 32'h0; m_ir_pc4 = 32'h4; m_v = 1'b0;
  endtask

  // One clock: drive inputs, predict, clock, compare.
  task automatic cyc(input logic s, input logic r, input logic [31:0] t);
    exp_t e;
    logic [31:0] tg;
    logic        cap;
    stall = s; redirect = r; redirect_pc = t;
    cap = (m_tt == 1'b0);
    if (cap) begin
      if (r || m_pend) begin
        tg = r ? t : m_tgt;
        m_pc   = {tg[31:2], 2'b00};
        m_mis  = m_mis | (tg[1:0] != 2'b00);
        m_pend = 1'b0;
        m_ir = NOP; m_v = 1'b0;
        e = '{ir: NOP, pc: m_ir_pc, pc4: m_ir_pc4, v: 1'b0, chk_pc: 1'b0};
      end else if (s) begin
        e = '{ir: m_ir, pc: m_ir_pc, pc4: m_ir_pc4, v: m_v, chk_pc: 1'b1};
      end else begin
        m_ir = mem_f(m_pc); m_ir_pc = m_pc; m_ir_pc4 = m_pc + 32'd4; m_v = 1'b1;
        e = '{ir: m_ir, pc: m_ir_pc, pc4: m_ir_pc4, v: 1'b1, chk_pc: 1'b1};
        m_pc = m_pc + 32'd4;
      end
      sb.push_back(e);
    end else if (r) begin
      m_pend = 1'b1;
      m_tgt  = t;
    end
    m_tt = ~m_tt;
    @(posedge clk);
    #1;
    chk("tick_tock", {31'b0, tick_tock}, {31'b0, m_tt});
    chk("fetch_en", {31'b0, fetch_en}, {31'b0, ~m_tt});
    chk("pc", mem_addr, m_pc);
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    if (cap) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ir", ir, e.ir);
        chk("ir_valid", {31'b0, ir_valid}, {31'b0, e.v});
        if (e.chk_pc) begin
          chk("ir_pc", ir_pc, e.pc);
          chk("ir_pc4", ir_pc4, e.pc4);
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, mem_addr, 32'h0);
    chk({tag, "_ir"}, ir, NOP);
    chk({tag, "_ir_pc"}, ir_pc, 32'h0);
    chk({tag, "_ir_pc4"}, ir_pc4, 32'h4);
    chk({tag, "_valid"}, {31'b0, ir_valid}, 32'h0);
    chk({tag, "_tt"}, {31'b0, tick_tock}, 32'h0);
    chk({tag, "_fetch_en"}, {31'b0, fetch_en}, 32'h1);
    chk({tag, "_misalign"}, {31'b0, misalign}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    #1;
    check_reset_vals("rst0");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequential fetch: captures on edges 1 and 3
    cyc(0, 0, 0);
    chk("T2_A", ir, mem_f(32'h0));
    chk("T2_A_pc", ir_pc, 32'h0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("T2_B", ir, mem_f(32'h4));
    chk("T2_B_pc", ir_pc, 32'h4);
    cyc(0, 0, 0);
    // Stall across capture with ir=B
    cyc(1, 0, 0);
    chk("T3_hold_ir", ir, mem_f(32'h4));
    chk("T3_hold_pc", mem_addr, 32'h8);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("T3_C", ir, mem_f(32'h8));
    chk("T3_C_pc", ir_pc, 32'h8);
    // Redirect in FETCH together with stall
    cyc(0, 0, 0);
    cyc(1, 1, 32'h40);
    chk("T4_nop", ir, NOP);
    chk("T4_valid", {31'b0, ir_valid}, 32'h0);
    chk("T4_pc", mem_addr, 32'h40);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("T4_ir", ir, mem_f(32'h40));
    chk("T4_ir_pc", ir_pc, 32'h40);
    chk("T4_ir_pc4", ir_pc4, 32'h44);
    // Redirect in DATA, then a live redirect on the capture edge wins
    cyc(0, 1, 32'h80);
    cyc(0, 1, 32'h90);
    chk("T5_pc", mem_addr, 32'h90);
    chk("T5_nop", ir, NOP);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("T5_ir", ir, mem_f(32'h90));
    chk("T5_ir_pc", ir_pc, 32'h90);
    // Pending redirect alone, applied despite stall
    cyc(0, 1, 32'hA0);
    cyc(1, 0, 0);
    chk("T5b_pc", mem_addr, 32'hA0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("T5b_ir", ir, mem_f(32'hA0));
    // Misaligned target and PC wrap
    cyc(0, 0, 0);
    cyc(0, 1, 32'hFFFF_FFFE);
    chk("T6_misalign", {31'b0, misalign}, 32'h1);
    chk("T6_pc", mem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("T6_ir_pc", ir_pc, 32'hFFFF_FFFC);
    chk("T6_ir_pc4", ir_pc4, 32'h0);
    chk("T6_wrap", mem_addr, 32'h0);
    chk("T6_sticky", {31'b0, misalign}, 32'h1);

    // Random traffic against the reference
    for (int i = 0; i < 60; i++) begin
      cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
          $urandom & 32'h0000_0FFF);
    end

    // Asynchronous reset mid-run, checked without any clock edge
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("T1");
    model_reset();
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 0);
    chk("post_rst_ir", ir, mem_f(32'h0));
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("post_rst_ir2", ir, mem_f(32'h4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
